// File: rtl/vape_pkg.sv
// rtl/vape_pkg.sv - shared state encodings and defaults for the exec latch
package vape_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] FAIL = 2'd3;

    localparam int VAPE_CNT_W = 8;

    typedef logic [1:0] vape_state_t;

endpackage

// File: rtl/vape_att_snap.sv
// rtl/vape_att_snap.sv - attestation req/ack edge tracking with exec snapshot
module vape_att_snap (
    input  logic clk,
    input  logic rst_n,
    input  logic att_req,
    input  logic exec_flag,
    output logic att_ack,
    output logic att_snap
);

    logic served;
    logic fire;

    // served stays set until att_req drops, so a held request acks only once
    assign fire = att_req && !att_ack && !served;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            att_ack  <= 1'b0;
            att_snap <= 1'b0;
            served   <= 1'b0;
        end else begin
            att_ack <= fire;
            served  <= att_req && (served || fire);
            if (fire) begin
                att_snap <= exec_flag;
            end
        end
    end

endmodule

// File: rtl/vape_exec_latch.sv
// rtl/vape_exec_latch.sv - ER control-flow FSM, sticky EXEC flag and violation count
module vape_exec_latch
    import vape_pkg::*;
#(
    parameter int N_MON = 3,
    parameter int CNT_W = VAPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      pc,
    input  logic [15:0]      ER_min,
    input  logic [15:0]      ER_max,
    input  logic [N_MON-1:0] mon_exec,
    input  logic             att_req,
    output logic             exec_flag,
    output logic             att_ack,
    output logic             att_snap,
    output logic [CNT_W-1:0] viol_cnt
);

    vape_state_t state_q;
    vape_state_t state_d;
    logic [15:0] pc_q;
    logic        all_ok;
    logic        in_er;
    logic        at_min;
    logic        cfg_bad;
    logic        viol_inc;

    assign all_ok  = &mon_exec;
    assign in_er   = (pc >= ER_min) && (pc <= ER_max);
    assign at_min  = (pc == ER_min);
    assign cfg_bad = (ER_min > ER_max);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= 16'h0000;
            viol_cnt <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc;
            if (viol_inc && (viol_cnt != {CNT_W{1'b1}})) begin
                viol_cnt <= viol_cnt + 1'b1;
            end
        end
    end

    // A bad region config overrides everything, including legal entry
    always_comb begin
        state_d = state_q;
        if (cfg_bad) begin
            state_d = IDLE;
        end else if (at_min && all_ok) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (!all_ok) begin
                        state_d = FAIL;
                    end else if (!in_er && (pc_q == ER_max)) begin
                        state_d = DONE;
                    end else if (!in_er) begin
                        state_d = FAIL;
                    end
                end
                DONE: begin
                    if (!all_ok) begin
                        state_d = FAIL;
                    end else if (in_er && !at_min) begin
                        state_d = FAIL;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        exec_flag = (state_q == DONE);
        viol_inc  = ((state_q == RUN) || (state_q == DONE)) && (state_d == FAIL);
    end

    vape_att_snap u_att_snap (
        .clk       (clk),
        .rst_n     (rst_n),
        .att_req   (att_req),
        .exec_flag (exec_flag),
        .att_ack   (att_ack),
        .att_snap  (att_snap)
    );

endmodule

// File: tb/tb_vape_exec_latch.sv
// tb/tb_vape_exec_latch.sv - scoreboard bench for vape_exec_latch
module tb_vape_exec_latch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic [15:0] er_min = 16'hE000;
    logic [15:0] er_max = 16'hE0FE;
    logic [2:0]  mon_exec = 3'b111;
    logic        att_req = 1'b0;

    logic       exec8, ack8, snap8;
    logic [7:0] viol8;
    logic       exec2, ack2, snap2;
    logic [1:0] viol2;

    typedef struct {
        string      name;
        logic       snap;
        logic       exec;
        logic [7:0] v8;
        logic [1:0] v2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_acks = 0;
    int   exp_acks = 0;
    logic prev_ack = 1'b0;

    always #5 clk = ~clk;

    vape_exec_latch dut8 (
        .clk(clk), .rst_n(rst_n), .pc(pc), .ER_min(er_min), .ER_max(er_max),
        .mon_exec(mon_exec), .att_req(att_req), .exec_flag(exec8),
        .att_ack(ack8), .att_snap(snap8), .viol_cnt(viol8)
    );

    vape_exec_latch #(.N_MON(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .pc(pc), .ER_min(er_min), .ER_max(er_max),
        .mon_exec(mon_exec), .att_req(att_req), .exec_flag(exec2),
        .att_ack(ack2), .att_snap(snap2), .viol_cnt(viol2)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack8) begin
            n_acks++;
            if (prev_ack) check("ack_single_cycle", 8'd1, 8'd0);
            if (sb.size() == 0) begin
                check("spurious_ack", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_snap"}, {7'd0, snap8}, {7'd0, e.snap});
                check({e.name, "_exec"}, {7'd0, exec8}, {7'd0, e.exec});
                check({e.name, "_viol8"}, viol8, e.v8);
                check({e.name, "_viol2"}, {6'd0, viol2}, {6'd0, e.v2});
                check({e.name, "_ack2"}, {6'd0, ack2, snap2}, {6'd0, 1'b1, e.snap});
            end
        end
        prev_ack = ack8;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] p);
        pc = p;
        tick();
    endtask

    task automatic chk(input string name, input logic s, input logic x,
                       input logic [7:0] v8, input logic [1:0] v2);
        exp_t e;
        e.name = name; e.snap = s; e.exec = x; e.v8 = v8; e.v2 = v2;
        sb.push_back(e);
        exp_acks++;
        att_req = 1'b1;
        tick();
        att_req = 1'b0;
        tick();
    endtask

    task automatic check_reset(input string name);
        check({name, "_exec"}, {7'd0, exec8}, 8'd0);
        check({name, "_ack"}, {7'd0, ack8}, 8'd0);
        check({name, "_snap"}, {7'd0, snap8}, 8'd0);
        check({name, "_viol8"}, viol8, 8'd0);
        check({name, "_viol2"}, {6'd0, viol2}, 8'd0);
    endtask

    initial begin
        exp_t e;
        tick();
        tick();
        check_reset("reset");
        rst_n = 1'b1;

        // 1: full walk through the region, legal exit
        go(16'hE000);
        for (int a = 16'hE002; a <= 16'hE0FE; a += 2) go(16'(a));
        go(16'hC000);
        chk("t1_done", 1'b1, 1'b1, 8'd0, 2'd0);

        // 2: monitor veto mid-region, then legal re-entry
        go(16'hE000);
        for (int a = 16'hE002; a <= 16'hE00E; a += 2) go(16'(a));
        mon_exec = 3'b110;
        go(16'hE010);
        mon_exec = 3'b111;
        chk("t2_fail", 1'b0, 1'b0, 8'd1, 2'd1);
        go(16'hE000);
        go(16'hE0FE);
        go(16'hC000);
        chk("t2_reentry", 1'b1, 1'b1, 8'd1, 2'd1);

        // 3: illegal exit, then mid-region re-entry from DONE
        go(16'hE000);
        go(16'hE020);
        go(16'hC000);
        chk("t3_bad_exit", 1'b0, 1'b0, 8'd2, 2'd2);
        go(16'hE000);
        go(16'hE0FE);
        go(16'hC000);
        go(16'hE040);
        chk("t3_mid_entry", 1'b0, 1'b0, 8'd3, 2'd3);

        // 4: held request while DONE drops to FAIL in the request cycle
        go(16'hE000);
        go(16'hE0FE);
        go(16'hC000);
        e.name = "t4_held_req"; e.snap = 1'b1; e.exec = 1'b0; e.v8 = 8'd4; e.v2 = 2'd3;
        sb.push_back(e);
        exp_acks++;
        pc = 16'hE040;
        att_req = 1'b1;
        repeat (4) tick();
        att_req = 1'b0;
        tick();

        // 5: saturation of the narrow counter, then bad region config
        go(16'hE000);
        go(16'hC000);
        chk("t5_sat", 1'b0, 1'b0, 8'd5, 2'd3);
        go(16'hE000);
        go(16'hE0FE);
        go(16'hC000);
        er_min = 16'hF000;
        er_max = 16'hE000;
        go(16'hF000);
        chk("t5_cfg_bad", 1'b0, 1'b0, 8'd5, 2'd3);

        // single-address region
        er_min = 16'hD000;
        er_max = 16'hD000;
        go(16'hD000);
        go(16'hC000);
        chk("t5_single", 1'b1, 1'b1, 8'd5, 2'd3);

        // 6: reset mid-RUN clears everything
        er_min = 16'hE000;
        er_max = 16'hE0FE;
        go(16'hE000);
        go(16'hE002);
        rst_n = 1'b0;
        go(16'hE004);
        check_reset("t6_reset");
        rst_n = 1'b1;
        go(16'hE0FE);
        go(16'hC000);
        chk("t6_idle", 1'b0, 1'b0, 8'd0, 2'd0);
        mon_exec = 3'b011;
        go(16'hE000);
        mon_exec = 3'b111;
        go(16'hE0FE);
        go(16'hC000);
        chk("t6_idle_veto", 1'b0, 1'b0, 8'd0, 2'd0);
        go(16'hE000);
        go(16'hE0FE);
        go(16'hC000);
        chk("t6_recover", 1'b1, 1'b1, 8'd1 - 8'd1, 2'd0);

        repeat (3) tick();
        check("sb_drained", 8'(sb.size()), 8'd0);
        check("ack_count", 8'(n_acks), 8'(exp_acks));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
